// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use stalls, mult/div occupancy stalls and
// taken-branch flushes, with saturating stall and flush cycle counters.
module hazard_stall_controller #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IF_ID_RegisterRs,
   input  logic [4:0]       IF_ID_RegisterRt,
   input  logic             UsesRt_ID,
   input  logic             MD_Req_ID,
   input  logic [4:0]       ID_EX_RegisterRt,
   input  logic             MemRead_EX,
   input  logic             Branch_Taken_EX,
   input  logic             md_done,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             md_start,
   output logic             md_abort,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // state   | meaning
   // RUN     | normal issue; hazards detected here
   // LS_WAIT | remaining load-use stall cycles (ls_cnt left, exits at 1)
   // MD_WAIT | mult/div busy; pipeline held until md_done
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LS_WAIT = 2'd1,
      MD_WAIT = 2'd2
   } state_t;

   localparam int LS_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) + 1 : 1;
   localparam logic [LS_W-1:0] LS_LOAD = LS_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [LS_W-1:0] LS_ONE  = LS_W'(1);
   localparam bit MULTI_STALL = (LOAD_STALL_CYCLES > 1);

   state_t          state, state_nxt;
   logic [LS_W-1:0] ls_cnt, ls_cnt_nxt;
   logic            load_use;
   logic            rs_match, rt_match;

   assign rs_match = (ID_EX_RegisterRt == IF_ID_RegisterRs);
   assign rt_match = UsesRt_ID & (ID_EX_RegisterRt == IF_ID_RegisterRt);
   assign load_use = MemRead_EX & (ID_EX_RegisterRt != 5'd0) & (rs_match | rt_match);

   always_comb begin
      state_nxt   = state;
      ls_cnt_nxt  = ls_cnt;
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      md_start    = 1'b0;
      md_abort    = 1'b0;

      if (reset) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
         state_nxt   = RUN;
         ls_cnt_nxt  = '0;
      end else begin
         unique case (state)
            RUN: begin
               if (Branch_Taken_EX) begin
                  IF_ID_Flush = 1'b1;
                  ID_EX_Flush = 1'b1;
               end else if (load_use) begin
                  PC_Write    = 1'b0;
                  IF_ID_Write = 1'b0;
                  ID_EX_Flush = 1'b1;
                  if (MULTI_STALL) begin
                     state_nxt  = LS_WAIT;
                     ls_cnt_nxt = LS_LOAD;
                  end
               end else if (MD_Req_ID) begin
                  md_start    = 1'b1;
                  PC_Write    = 1'b0;
                  IF_ID_Write = 1'b0;
                  ID_EX_Flush = 1'b1;
                  state_nxt   = MD_WAIT;
               end
            end

            LS_WAIT: begin
               if (Branch_Taken_EX) begin
                  IF_ID_Flush = 1'b1;
                  ID_EX_Flush = 1'b1;
                  state_nxt   = RUN;
                  ls_cnt_nxt  = '0;
               end else begin
                  PC_Write    = 1'b0;
                  IF_ID_Write = 1'b0;
                  ID_EX_Flush = 1'b1;
                  if (ls_cnt == LS_ONE) begin
                     state_nxt  = RUN;
                     ls_cnt_nxt = '0;
                  end else begin
                     ls_cnt_nxt = ls_cnt - LS_ONE;
                  end
               end
            end

            MD_WAIT: begin
               // a taken branch here is a protocol error; the flush wins over md_done
               if (Branch_Taken_EX) begin
                  IF_ID_Flush = 1'b1;
                  ID_EX_Flush = 1'b1;
                  md_abort    = 1'b1;
                  state_nxt   = RUN;
               end else if (md_done) begin
                  state_nxt = RUN;
               end else begin
                  PC_Write    = 1'b0;
                  IF_ID_Write = 1'b0;
                  ID_EX_Flush = 1'b1;
               end
            end

            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         ls_cnt <= '0;
      end else begin
         state  <= state_nxt;
         ls_cnt <= ls_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (!PC_Write && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
         if (IF_ID_Flush && (flush_count != {CNT_W{1'b1}}))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three instances (1-cycle stall, 3-cycle
// stall, 4-bit counters) share stimulus; expected output vectors are queued.
module tb_hazard_stall_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs, rt, ex_rt;
   logic       uses_rt, md_req, mem_read, br_taken, md_done;

   logic [2:0]  pc_w, ifid_w, ifid_f, idex_f, start, abort;
   logic [15:0] sc1, fc1, sc3, fc3;
   logic [3:0]  scs, fcs;
   logic [5:0]  o1, o3, os;

   // output vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, md_start, md_abort}
   localparam logic [5:0] O_RUN   = 6'b110000;
   localparam logic [5:0] O_STALL = 6'b000100;
   localparam logic [5:0] O_START = 6'b000110;
   localparam logic [5:0] O_BR    = 6'b111100;
   localparam logic [5:0] O_ABORT = 6'b111101;
   localparam logic [5:0] O_RST   = 6'b001100;

   logic [5:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign o1 = {pc_w[0], ifid_w[0], ifid_f[0], idex_f[0], start[0], abort[0]};
   assign o3 = {pc_w[1], ifid_w[1], ifid_f[1], idex_f[1], start[1], abort[1]};
   assign os = {pc_w[2], ifid_w[2], ifid_f[2], idex_f[2], start[2], abort[2]};

   hazard_stall_controller #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt),
      .UsesRt_ID(uses_rt), .MD_Req_ID(md_req), .ID_EX_RegisterRt(ex_rt),
      .MemRead_EX(mem_read), .Branch_Taken_EX(br_taken), .md_done(md_done),
      .PC_Write(pc_w[0]), .IF_ID_Write(ifid_w[0]), .IF_ID_Flush(ifid_f[0]),
      .ID_EX_Flush(idex_f[0]), .md_start(start[0]), .md_abort(abort[0]),
      .stall_count(sc1), .flush_count(fc1));

   hazard_stall_controller #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
      .clk(clk), .reset(reset), .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt),
      .UsesRt_ID(uses_rt), .MD_Req_ID(md_req), .ID_EX_RegisterRt(ex_rt),
      .MemRead_EX(mem_read), .Branch_Taken_EX(br_taken), .md_done(md_done),
      .PC_Write(pc_w[1]), .IF_ID_Write(ifid_w[1]), .IF_ID_Flush(ifid_f[1]),
      .ID_EX_Flush(idex_f[1]), .md_start(start[1]), .md_abort(abort[1]),
      .stall_count(sc3), .flush_count(fc3));

   hazard_stall_controller #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt),
      .UsesRt_ID(uses_rt), .MD_Req_ID(md_req), .ID_EX_RegisterRt(ex_rt),
      .MemRead_EX(mem_read), .Branch_Taken_EX(br_taken), .md_done(md_done),
      .PC_Write(pc_w[2]), .IF_ID_Write(ifid_w[2]), .IF_ID_Flush(ifid_f[2]),
      .ID_EX_Flush(idex_f[2]), .md_start(start[2]), .md_abort(abort[2]),
      .stall_count(scs), .flush_count(fcs));

   task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs_i,
                        input logic [4:0] rt_i, input logic ur, input logic mdr,
                        input logic br, input logic dn, input logic [5:0] e);
      @(negedge clk);
      mem_read = mr;  ex_rt = xrt;  rs = rs_i;  rt = rt_i;
      uses_rt  = ur;  md_req = mdr; br_taken = br; md_done = dn;
      exp_q.push_back(e);
   endtask

   task automatic set_idle();
      mem_read = 0; ex_rt = 0; rs = 0; rt = 0;
      uses_rt = 0; md_req = 0; br_taken = 0; md_done = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_idle();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] e;
      @(negedge clk);
      set_idle();
      reset = 1'b1;
      exp_q.push_back(O_RST);
      #2;
      e = exp_q.pop_front(); n_cmp++;
      if (o1 !== e) begin n_err++; $display("FAIL reset_outputs got=%b exp=%b", o1, e); end
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back(O_RUN);
      #2;
      e = exp_q.pop_front(); n_cmp++;
      if (o1 !== e) begin n_err++; $display("FAIL reset_release got=%b exp=%b", o1, e); end
      @(negedge clk);
      n_cmp++;
      if (sc1 !== 16'd0 || fc1 !== 16'd0) begin
         n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", sc1, fc1);
      end
   endtask

   task automatic test_load_use();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       drive(1, 5'd5, 5'd5, 5'd9, 0, 0, 0, 0, O_STALL);
            default: drive(0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0, O_RUN);
         endcase
         #2;
         e = exp_q.pop_front(); n_cmp++;
         if (o1 !== e) begin n_err++; $display("FAIL load_use cyc%0d got=%b exp=%b", i, o1, e); end
      end
      @(negedge clk);
      n_cmp++;
      if (sc1 !== 16'd1) begin n_err++; $display("FAIL load_use_stall_count got=%0d exp=1", sc1); end
   endtask

   task automatic test_rt_match();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       drive(1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, O_RUN);
            1:       drive(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, O_RUN);
            2:       drive(1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, O_STALL);
            default: drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RUN);
         endcase
         #2;
         e = exp_q.pop_front(); n_cmp++;
         if (o1 !== e) begin n_err++; $display("FAIL rt_match cyc%0d got=%b exp=%b", i, o1, e); end
      end
   endtask

   task automatic test_long_stall();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         case (i)
            0, 4:    drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, O_STALL);
            1, 2:    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_STALL);
            5:       drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_BR);
            default: drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RUN);
         endcase
         #2;
         e = exp_q.pop_front(); n_cmp++;
         if (o3 !== e) begin n_err++; $display("FAIL long_stall cyc%0d got=%b exp=%b", i, o3, e); end
         if (i == 3) begin
            @(negedge clk);
            n_cmp++;
            if (sc3 !== 16'd3) begin n_err++; $display("FAIL long_stall_count got=%0d exp=3", sc3); end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (sc3 !== 16'd4 || fc3 !== 16'd1) begin
         n_err++; $display("FAIL ls_abort_counts got=%0d/%0d exp=4/1", sc3, fc3);
      end
   endtask

   task automatic test_md();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i == 0)      drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_START);
         else if (i < 8)  drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_STALL);
         else if (i == 8) drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, O_RUN);
         else             drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RUN);
         #2;
         e = exp_q.pop_front(); n_cmp++;
         if (o1 !== e) begin n_err++; $display("FAIL md cyc%0d got=%b exp=%b", i, o1, e); end
      end
      @(negedge clk);
      n_cmp++;
      if (sc1 !== 16'd8) begin n_err++; $display("FAIL md_stall_count got=%0d exp=8", sc1); end
   endtask

   task automatic test_md_abort();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_START);
            1:       drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, O_ABORT);
            default: drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RUN);
         endcase
         #2;
         e = exp_q.pop_front(); n_cmp++;
         if (o1 !== e) begin n_err++; $display("FAIL md_abort cyc%0d got=%b exp=%b", i, o1, e); end
      end
   endtask

   task automatic test_branch_priority();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) drive(1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0, O_BR);
         else        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RUN);
         #2;
         e = exp_q.pop_front(); n_cmp++;
         if (o1 !== e) begin n_err++; $display("FAIL branch_prio cyc%0d got=%b exp=%b", i, o1, e); end
      end
      @(negedge clk);
      n_cmp++;
      if (fc1 !== 16'd1 || sc1 !== 16'd0) begin
         n_err++; $display("FAIL branch_counts got=%0d/%0d exp=1/0", fc1, sc1);
      end
   endtask

   task automatic test_reset_mid_md();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (i == 0)     drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_START);
         else if (i < 4) drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_STALL);
         else if (i == 4) begin
            @(negedge clk);
            reset = 1'b1;
            exp_q.push_back(O_RST);
         end else begin
            @(negedge clk);
            reset = 1'b0;
            set_idle();
            exp_q.push_back(O_RUN);
         end
         #2;
         e = exp_q.pop_front(); n_cmp++;
         if (o1 !== e) begin n_err++; $display("FAIL reset_mid_md cyc%0d got=%b exp=%b", i, o1, e); end
      end
      @(negedge clk);
      n_cmp++;
      if (sc1 !== 16'd0 || fc1 !== 16'd0) begin
         n_err++; $display("FAIL reset_mid_md_counts got=%0d/%0d exp=0/0", sc1, fc1);
      end
   endtask

   task automatic test_saturation();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 22; i++) begin
         if (i == 0)       drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_START);
         else if (i < 20)  drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_STALL);
         else if (i == 20) drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, O_RUN);
         else              drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RUN);
         #2;
         e = exp_q.pop_front(); n_cmp++;
         if (os !== e) begin n_err++; $display("FAIL saturation cyc%0d got=%b exp=%b", i, os, e); end
      end
      @(negedge clk);
      n_cmp++;
      if (scs !== 4'd15) begin n_err++; $display("FAIL sat_stall_count got=%0d exp=15", scs); end
      n_cmp++;
      if (sc1 !== 16'd20) begin n_err++; $display("FAIL wide_stall_count got=%0d exp=20", sc1); end
   endtask

   initial begin
      reset = 1'b1;
      set_idle();
      test_reset();
      test_load_use();
      test_rt_match();
      test_long_stall();
      test_md();
      test_md_abort();
      test_branch_priority();
      test_reset_mid_md();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired before bench completion");
      $fatal(1, "timeout");
   end

endmodule
